// File: rtl/radd_mul_ctrl_if.sv
// Handshake and strobe bundle between a requester and the repeated-addition
// multiplier controller. The master drives start/din; the controller drives the rest.
interface radd_mul_ctrl_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             ld_a;
    logic             clr_p;
    logic             ld_p;
    logic             eqz;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;

    modport master (
        output start, din,
        input  ld_a, clr_p, ld_p, eqz, busy, done, count
    );

    modport slave (
        input  start, din,
        output ld_a, clr_p, ld_p, eqz, busy, done, count
    );
endinterface

// File: rtl/radd_mul_ctrl.sv
// Control FSM and multiplier down-counter for a repeated-addition multiplier:
// loads A, latches B, then issues one P <= P + A strobe per count until zero.
module radd_mul_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    radd_mul_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt;
    logic             cnt_z;

    assign cnt_z     = (cnt == '0);
    assign bus.eqz   = cnt_z;
    assign bus.count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Decrement is gated on non-zero so the counter can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      cnt <= '0;
        else if (state == LOAD_B)        cnt <= bus.din;
        else if (state == ADD && !cnt_z) cnt <= cnt - 1'b1;
    end

    always_comb begin
        state_nxt = IDLE;
        bus.ld_a  = 1'b0;
        bus.clr_p = 1'b0;
        bus.ld_p  = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE:   state_nxt = bus.start ? LOAD_A : IDLE;
            LOAD_A: begin
                bus.ld_a  = 1'b1;
                bus.clr_p = 1'b1;
                bus.busy  = 1'b1;
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                bus.busy  = 1'b1;
                state_nxt = ADD;
            end
            ADD: begin
                bus.busy  = 1'b1;
                bus.ld_p  = !cnt_z;
                state_nxt = cnt_z ? DONE : ADD;
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_radd_mul_ctrl.sv
// Directed bench for radd_mul_ctrl: vector table of {A, B, expected P} plus
// hand sequences for mid-operation reset and start held high.
module tb_radd_mul_ctrl;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    radd_mul_ctrl_if #(.WIDTH(WIDTH)) bus ();

    radd_mul_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Downstream A and P registers driven by the controller strobes.
    logic [WIDTH-1:0] a_reg, p_reg;
    always @(posedge clk) begin
        if (bus.ld_a) a_reg <= bus.din;
        if (bus.clr_p)     p_reg <= '0;
        else if (bus.ld_p) p_reg <= p_reg + a_reg;
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] p;
    } vec_t;

    vec_t vecs[7];
    int   nvec = 0;
    int   nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation; din carries A/B only in LOAD_A/LOAD_B and noise elsewhere.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] p_exp);
        int bi, n_lda, n_ldp, done_cyc, ldp_err, cnt_err;
        bi = int'(b);
        n_lda = 0; n_ldp = 0; done_cyc = -1; ldp_err = 0; cnt_err = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = 16'($urandom);
        @(posedge clk);
        for (int cyc = 1; cyc <= bi + 10; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == 1)      bus.din = a;
            else if (cyc == 2) bus.din = b;
            else               bus.din = 16'($urandom);
            if (bus.ld_a) n_lda++;
            if (bus.ld_p) n_ldp++;
            if (bus.ld_p !== (cyc >= 3 && cyc < 3 + bi)) ldp_err++;
            if (cyc >= 3 && cyc <= 3 + bi) begin
                if (bus.count !== 16'(bi - (cyc - 3))) cnt_err++;
                if (bus.eqz !== (cyc == 3 + bi)) cnt_err++;
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
        end
        check($sformatf("done_cycle b=%0h", b), done_cyc, bi + 4);
        check($sformatf("ld_a_pulses b=%0h", b), n_lda, 1);
        check($sformatf("ld_p_pulses b=%0h", b), n_ldp, bi);
        check($sformatf("ld_p_timing b=%0h", b), ldp_err, 0);
        check($sformatf("count_seq b=%0h", b), cnt_err, 0);
        check($sformatf("product a=%0h b=%0h", a, b), p_reg, p_exp);
        check($sformatf("done_busy b=%0h", b), bus.busy, 1);
        @(negedge clk);
        check($sformatf("idle_after b=%0h", b), {bus.busy, bus.done, bus.eqz, bus.count}, {3'b001, 16'h0});
    endtask

    initial begin
        int n_lda, n_ldp, n_done, hit;

        vecs[0] = '{a: 16'h0007, b: 16'h0003, p: 16'h0015};
        vecs[1] = '{a: 16'h1234, b: 16'h0000, p: 16'h0000};
        vecs[2] = '{a: 16'h0000, b: 16'h0005, p: 16'h0000};
        vecs[3] = '{a: 16'h0003, b: 16'h0001, p: 16'h0003};
        vecs[4] = '{a: 16'hFFFF, b: 16'h0002, p: 16'hFFFE};
        vecs[5] = '{a: 16'h0001, b: 16'h00FF, p: 16'h00FF};
        vecs[6] = '{a: 16'h0001, b: 16'hFFFF, p: 16'hFFFF};

        bus.start = 1'b0;
        bus.din   = '0;
        #12;
        check("reset_outputs", {bus.ld_a, bus.clr_p, bus.ld_p, bus.busy, bus.done, bus.eqz, bus.count},
              {6'b000001, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

        // Reset asserted during the third ld_p cycle of A=5, B=7.
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        hit = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.din = (cyc == 1) ? 16'd5 : (cyc == 2) ? 16'd7 : 16'($urandom);
            if (cyc == 5) hit = bus.ld_p;
        end
        check("third_ldp_present", hit, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_add", {bus.ld_a, bus.clr_p, bus.ld_p, bus.busy, bus.done, bus.eqz, bus.count},
              {6'b000001, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus.done || bus.busy) n_done++;
        end
        check("no_activity_after_reset", n_done, 0);

        // start held high for 30 cycles, A=B=2: a new op every 7 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = 16'd2;
        @(posedge clk);
        n_lda = 0; n_ldp = 0; n_done = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (bus.ld_a) n_lda++;
            if (bus.ld_p) n_ldp++;
            if (bus.done) n_done++;
        end
        bus.start = 1'b0;
        check("held_start_ld_a", n_lda, 5);
        check("held_start_ld_p", n_ldp, 8);
        check("held_start_done", n_done, 4);
        hit = 0;
        for (int cyc = 0; cyc < 20 && hit == 0; cyc++) begin
            @(negedge clk);
            if (bus.done) hit = 1;
        end
        check("held_start_drain_done", hit, 1);
        check("held_start_product", p_reg, 16'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
